audio_sample_player: RTL

- Downstream consumer of the divided sample clock in the Talking Calculator audio path.
- On each rising edge of the divided clock it emits one 16-bit audio sample.
- Samples are fetched as packed 32-bit words from flash over a waitrequest/readdatavalid read interface.
- Plays one phrase (start_addr..end_addr inclusive) per start pulse, optionally looping, and reports done to the phrase sequencer.

---
 rtl/audio_sample_player.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/audio_sample_player.sv
// audio_sample_player: fetches packed 32-bit words from flash and emits one
// 16-bit sample (low half first, then high half) per rising edge of the
// divided sample clock. Plays start_addr..end_addr inclusive, optionally looping.
// Optional feature macro: AUDIO_UNDERRUN_CNT_EN adds the underrun_cnt output.
module audio_sample_player #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 32,
  parameter int SAMPLE_W = 16
) (
  input  logic                clkin,
  input  logic                reset,
  input  logic                sample_clk,
  input  logic                start,
  input  logic                stop,
  input  logic                loop,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  output logic                mem_read,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_waitrequest,
  input  logic                mem_readdatavalid,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic [SAMPLE_W-1:0] audio_out,
  output logic                audio_valid,
  output logic                busy,
  output logic                done
`ifdef AUDIO_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         underrun_cnt
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_PLAY_LO   = 3'd3,
    ST_PLAY_HI   = 3'd4,
    ST_FINISH    = 3'd5,
    ST_DRAIN     = 3'd6
  } state_t;

  state_t              state_reg, state_next;
  logic                t1_reg, t2_reg, tick_pending_reg;
  logic [ADDR_W-1:0]   addr_reg, start_addr_reg, end_addr_reg;
  logic [DATA_W-1:0]   word_reg;
  logic [SAMPLE_W-1:0] audio_out_reg;
  logic                audio_valid_reg;

  logic rise, consume, at_end, accept_start, capture;

  // sample_clk is only ever sampled as data; a rise is seen one flop after sync
  assign rise         = t1_reg & ~t2_reg;
  assign consume      = tick_pending_reg & ~stop &
                        ((state_reg == ST_PLAY_LO) || (state_reg == ST_PLAY_HI));
  assign at_end       = (addr_reg == end_addr_reg);
  assign accept_start = (state_reg == ST_IDLE) & start & ~stop;
  assign capture      = (state_reg == ST_WAIT_DATA) & mem_readdatavalid & ~stop;

  // state register
  always_ff @(posedge clkin) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // next-state logic; stop overrides every other transition outside IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (start && !stop) state_next = ST_FETCH;
      ST_FETCH:     if (stop) state_next = ST_FINISH;
                    else if (!mem_waitrequest) state_next = ST_WAIT_DATA;
      ST_WAIT_DATA: if (stop) state_next = mem_readdatavalid ? ST_FINISH : ST_DRAIN;
                    else if (mem_readdatavalid) state_next = ST_PLAY_LO;
      ST_PLAY_LO:   if (stop) state_next = ST_FINISH;
                    else if (tick_pending_reg) state_next = ST_PLAY_HI;
      ST_PLAY_HI:   if (stop) state_next = ST_FINISH;
                    else if (tick_pending_reg) state_next = (at_end && !loop) ? ST_FINISH : ST_FETCH;
      ST_FINISH:    state_next = ST_IDLE;
      ST_DRAIN:     if (mem_readdatavalid) state_next = ST_FINISH;
      default:      state_next = ST_IDLE;
    endcase
  end

  // state-decoded outputs; an unaccepted request is withdrawn as soon as stop shows up
  always_comb begin
    mem_read = 1'b0;
    mem_addr = '0;
    busy     = (state_reg != ST_IDLE);
    done     = (state_reg == ST_FINISH);
    if (state_reg == ST_FETCH && !stop) begin
      mem_read = 1'b1;
      mem_addr = addr_reg;
    end
  end

  // tick synchroniser, address/word registers and the registered sample output
  always_ff @(posedge clkin) begin
    if (reset) begin
      t1_reg           <= 1'b0;
      t2_reg           <= 1'b0;
      tick_pending_reg <= 1'b0;
      addr_reg         <= '0;
      start_addr_reg   <= '0;
      end_addr_reg     <= '0;
      word_reg         <= '0;
      audio_out_reg    <= '0;
      audio_valid_reg  <= 1'b0;
    end else begin
      t1_reg           <= sample_clk;
      t2_reg           <= t1_reg;
      // a rise while already pending is simply absorbed (missed tick)
      tick_pending_reg <= rise | (tick_pending_reg & ~consume);
      audio_valid_reg  <= consume;
      if (accept_start) begin
        start_addr_reg <= start_addr;
        end_addr_reg   <= end_addr;
        addr_reg       <= start_addr;
      end
      if (capture) word_reg <= mem_readdata;
      if (consume) begin
        if (state_reg == ST_PLAY_LO) begin
          audio_out_reg <= word_reg[SAMPLE_W-1:0];
        end else begin
          audio_out_reg <= word_reg[DATA_W-1:SAMPLE_W];
          addr_reg      <= at_end ? start_addr_reg
                                  : addr_reg + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign audio_out   = audio_out_reg;
  assign audio_valid = audio_valid_reg;

`ifdef AUDIO_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_reg;
  logic        missed;

  assign missed = rise & tick_pending_reg & ~consume;

  // saturating count of missed ticks, restarted for every accepted phrase
  always_ff @(posedge clkin) begin
    if (reset)                                     underrun_cnt_reg <= '0;
    else if (accept_start)                         underrun_cnt_reg <= '0;
    else if (missed && underrun_cnt_reg != 16'hFFFF) underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
  end

  assign underrun_cnt = underrun_cnt_reg;
`endif

endmodule
